// File: rtl/rv_multicycle_ctrl_if.sv
// Handshake and control bundle between the multi-cycle sequencer and the RISC-V datapath.
// The master side is the sequencer; the slave side is the datapath/memory environment.
interface rv_multicycle_ctrl_if #(
   parameter int RETIRE_W = 16
);
   logic                run;
   logic [6:0]          opcode;
   logic                zero;
   logic                mem_ready;
   logic                imem_req;
   logic                ir_write;
   logic                pc_write;
   logic                pc_src;
   logic                reg_write;
   logic                mem_read;
   logic                mem_write;
   logic                alu_src;
   logic                mem_to_reg;
   logic [1:0]          alu_op;
   logic                busy;
   logic                illegal;
   logic                timeout;
   logic [2:0]          state;
   logic [RETIRE_W-1:0] retired;

   modport master (
      input  run, opcode, zero, mem_ready,
      output imem_req, ir_write, pc_write, pc_src, reg_write, mem_read, mem_write,
             alu_src, mem_to_reg, alu_op, busy, illegal, timeout, state, retired
   );

   modport slave (
      output run, opcode, zero, mem_ready,
      input  imem_req, ir_write, pc_write, pc_src, reg_write, mem_read, mem_write,
             alu_src, mem_to_reg, alu_op, busy, illegal, timeout, state, retired
   );
endinterface

// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for R-type, ld, sd and beq with a
// ready handshake on memory accesses, a retire counter and sticky illegal/timeout halts.
module rv_multicycle_ctrl #(
   parameter int RETIRE_W    = 16,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic                 clk,
   input  logic                 reset,
   rv_multicycle_ctrl_if.master bus
);

   localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6
   } state_e;

   typedef enum logic [1:0] {
      C_R   = 2'd0,
      C_LD  = 2'd1,
      C_SD  = 2'd2,
      C_BEQ = 2'd3
   } cls_e;

   state_e              state_q, state_d;
   cls_e                cls_q, cls_d;
   logic                illegal_q, illegal_d;
   logic                timeout_q, timeout_d;
   logic [WAIT_W-1:0]   wait_q, wait_d;
   logic [RETIRE_W-1:0] retired_q, retired_d;
   logic                retire;
   logic                expire;

   // The expiring sample is the MEM_TIMEOUT-th consecutive not-ready edge; a ready on it wins.
   assign expire = (MEM_TIMEOUT != 0) && (int'(wait_q) == MEM_TIMEOUT - 1);

   always_comb begin
      state_d   = state_q;
      cls_d     = cls_q;
      illegal_d = illegal_q;
      timeout_d = timeout_q;
      wait_d    = wait_q;
      retired_d = retired_q;
      retire    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.run) begin
               state_d = S_FETCH;
               wait_d  = '0;
            end
         end
         S_FETCH: begin
            if (bus.mem_ready) begin
               state_d = S_DECODE;
            end else if (expire) begin
               state_d   = S_HALT;
               timeout_d = 1'b1;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         S_DECODE: begin
            state_d = S_EXEC;
            unique case (bus.opcode)
               7'b0110011: cls_d = C_R;
               7'b0000011: cls_d = C_LD;
               7'b0100011: cls_d = C_SD;
               7'b1100011: cls_d = C_BEQ;
               default: begin
                  state_d   = S_HALT;
                  illegal_d = 1'b1;
               end
            endcase
         end
         S_EXEC: begin
            unique case (cls_q)
               C_R:       state_d = S_WB;
               C_LD, C_SD: begin
                  state_d = S_MEM;
                  wait_d  = '0;
               end
               default:   retire = 1'b1;
            endcase
         end
         S_MEM: begin
            if (bus.mem_ready) begin
               if (cls_q == C_LD) state_d = S_WB;
               else               retire  = 1'b1;
            end else if (expire) begin
               state_d   = S_HALT;
               timeout_d = 1'b1;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         S_WB:    retire = 1'b1;
         default: state_d = S_HALT;
      endcase
      // run is only looked at here and in IDLE, so a mid-instruction drop still completes.
      if (retire) begin
         retired_d = retired_q + RETIRE_W'(1);
         state_d   = bus.run ? S_FETCH : S_IDLE;
         wait_d    = '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         cls_q     <= C_R;
         illegal_q <= 1'b0;
         timeout_q <= 1'b0;
         wait_q    <= '0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         cls_q     <= cls_d;
         illegal_q <= illegal_d;
         timeout_q <= timeout_d;
         wait_q    <= wait_d;
         retired_q <= retired_d;
      end
   end

   // Datapath enables depend only on state, the latched class and the live ready/zero inputs.
   always_comb begin
      bus.imem_req   = 1'b0;
      bus.ir_write   = 1'b0;
      bus.pc_write   = 1'b0;
      bus.pc_src     = 1'b0;
      bus.reg_write  = 1'b0;
      bus.mem_read   = 1'b0;
      bus.mem_write  = 1'b0;
      bus.alu_src    = 1'b0;
      bus.mem_to_reg = 1'b0;
      bus.alu_op     = 2'b00;
      if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
         bus.alu_src = (cls_q == C_LD) || (cls_q == C_SD);
         bus.alu_op  = (cls_q == C_R) ? 2'b10 : ((cls_q == C_BEQ) ? 2'b01 : 2'b00);
      end
      case (state_q)
         S_FETCH: begin
            bus.imem_req = 1'b1;
            bus.ir_write = bus.mem_ready;
         end
         S_EXEC: begin
            if (cls_q == C_BEQ) begin
               bus.pc_write = 1'b1;
               bus.pc_src   = bus.zero;
            end
         end
         S_MEM: begin
            bus.mem_read  = (cls_q == C_LD);
            bus.mem_write = (cls_q == C_SD);
            bus.pc_write  = (cls_q == C_SD) && bus.mem_ready;
         end
         S_WB: begin
            bus.reg_write  = 1'b1;
            bus.mem_to_reg = (cls_q == C_LD);
            bus.pc_write   = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.busy    = (state_q != S_IDLE) && (state_q != S_HALT);
   assign bus.illegal = illegal_q;
   assign bus.timeout = timeout_q;
   assign bus.state   = state_q;
   assign bus.retired = retired_q;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Randomized bench for rv_multicycle_ctrl: an instruction-level model expands each
// instruction into its expected per-cycle outputs, compared every cycle on the falling edge.
module tb_rv_multicycle_ctrl;

   localparam int RW     = 4;
   localparam int MEM_TO = 15;

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_LD  = 7'b0000011;
   localparam logic [6:0] OP_SD  = 7'b0100011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_BAD = 7'b1111111;

   typedef struct packed {
      logic       imem_req;
      logic       ir_write;
      logic       pc_write;
      logic       pc_src;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       alu_src;
      logic       mem_to_reg;
      logic [1:0] alu_op;
   } en_t;

   logic clk = 1'b0;
   logic reset = 1'b0;

   rv_multicycle_ctrl_if #(.RETIRE_W(RW)) bus ();

   rv_multicycle_ctrl #(.RETIRE_W(RW), .MEM_TIMEOUT(MEM_TO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   logic [20:0] obs;
   assign obs = {bus.imem_req, bus.ir_write, bus.pc_write, bus.pc_src, bus.reg_write,
                 bus.mem_read, bus.mem_write, bus.alu_src, bus.mem_to_reg, bus.alu_op,
                 bus.busy, bus.illegal, bus.timeout, bus.state, bus.retired};

   int          vectors     = 0;
   int          miscompares = 0;
   logic [20:0] exp_vec     = '0;
   logic        exp_valid   = 1'b0;
   string       tag         = "reset";

   logic [RW-1:0] m_retired = '0;
   logic          m_illegal = 1'b0;
   logic          m_timeout = 1'b0;
   logic          m_idle    = 1'b1;
   logic          m_halt    = 1'b0;
   int            last_len  = 0;
   int            abort_mem = -1;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got %h want %h (t=%0t)", nm, got, want, $time);
      end
   endtask

   always @(negedge clk) begin
      if (exp_valid) chk(tag, 32'(obs), 32'(exp_vec));
   end

   task automatic rand_in();
      bus.run       = 1'($urandom);
      bus.zero      = 1'($urandom);
      bus.mem_ready = 1'($urandom);
      bus.opcode    = 7'($urandom);
   endtask

   task automatic expect_step(input logic [2:0] st, input en_t e);
      exp_vec   = {e, (st != 3'd0 && st != 3'd6), m_illegal, m_timeout, st, m_retired};
      exp_valid = 1'b1;
      last_len++;
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      m_retired = '0;
      m_illegal = 1'b0;
      m_timeout = 1'b0;
      m_idle    = 1'b1;
      m_halt    = 1'b0;
   endtask

   task automatic do_reset();
      exp_valid = 1'b0;
      rand_in();
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("reset_state", 32'(obs), 32'd0);
      reset = 1'b1;
      model_clear();
   endtask

   task automatic retire(input logic ra);
      m_retired = m_retired + 1'b1;
      m_idle    = !ra;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         rand_in();
         bus.run = 1'b0;
         expect_step(3'd0, '0);
      end
   endtask

   task automatic halt_hold(input int n);
      for (int i = 0; i < n; i++) begin
         rand_in();
         bus.run = 1'b1;
         expect_step(3'd6, '0);
      end
   endtask

   // One instruction: fs/ms = not-ready samples before ready in FETCH/MEM, z = zero flag, ra = run at retire.
   task automatic run_instr(input logic [6:0] op, input int fs, input int ms, input logic z, input logic ra);
      en_t        e;
      en_t        b;
      logic       is_r, is_ld, is_sd, is_bq;
      is_r  = (op == OP_R);
      is_ld = (op == OP_LD);
      is_sd = (op == OP_SD);
      is_bq = (op == OP_BEQ);
      b            = '0;
      b.alu_src    = is_ld | is_sd;
      b.alu_op     = is_r ? 2'b10 : (is_bq ? 2'b01 : 2'b00);
      if (m_halt) return;
      if (m_idle) begin
         rand_in();
         bus.run = 1'b1;
         expect_step(3'd0, '0);
         m_idle = 1'b0;
      end
      last_len = 0;
      for (int i = 0; i <= fs; i++) begin
         rand_in();
         bus.mem_ready = (i == fs);
         e = '0;
         e.imem_req = 1'b1;
         e.ir_write = (i == fs);
         expect_step(3'd1, e);
         if (i != fs && i == MEM_TO - 1) begin
            m_timeout = 1'b1;
            m_halt    = 1'b1;
            return;
         end
      end
      rand_in();
      bus.opcode = op;
      expect_step(3'd2, '0);
      if (!(is_r | is_ld | is_sd | is_bq)) begin
         m_illegal = 1'b1;
         m_halt    = 1'b1;
         return;
      end
      rand_in();
      bus.opcode = op;
      e = b;
      if (is_bq) begin
         bus.zero   = z;
         bus.run    = ra;
         e.pc_write = 1'b1;
         e.pc_src   = z;
      end
      expect_step(3'd3, e);
      if (is_bq) begin
         retire(ra);
         return;
      end
      if (is_ld | is_sd) begin
         for (int i = 0; i <= ms; i++) begin
            rand_in();
            bus.opcode    = op;
            bus.mem_ready = (i == ms);
            e = b;
            e.mem_read  = is_ld;
            e.mem_write = is_sd;
            if (i == abort_mem) begin
               bus.mem_ready = 1'b0;
               exp_valid = 1'b0;
               #2;
               reset = 1'b0;
               #1;
               chk("reset_mid_mem", 32'(obs), 32'd0);
               @(posedge clk);
               #1;
               reset = 1'b1;
               model_clear();
               abort_mem = -1;
               return;
            end
            if (is_sd && i == ms) begin
               e.pc_write = 1'b1;
               bus.run    = ra;
            end
            expect_step(3'd4, e);
            if (is_sd && i == ms) begin
               retire(ra);
               return;
            end
            if (i != ms && i == MEM_TO - 1) begin
               m_timeout = 1'b1;
               m_halt    = 1'b1;
               return;
            end
         end
      end
      rand_in();
      bus.opcode = op;
      bus.run    = ra;
      e = b;
      e.reg_write  = 1'b1;
      e.mem_to_reg = is_ld;
      e.pc_write   = 1'b1;
      expect_step(3'd5, e);
      retire(ra);
   endtask

   function automatic int rnd_stall();
      int r;
      r = int'($urandom_range(0, 7));
      return (r < 6) ? int'($urandom_range(0, 2)) : int'($urandom_range(3, 14));
   endfunction

   initial begin
      logic [6:0] ops [4];
      ops[0] = OP_R; ops[1] = OP_LD; ops[2] = OP_SD; ops[3] = OP_BEQ;
      rand_in();
      repeat (2) @(posedge clk);
      #1;
      do_reset();

      tag = "r_type";
      run_instr(OP_R, 0, 0, 1'b0, 1'b1);
      chk("r_len", 32'(last_len), 32'd4);
      chk("r_retired", 32'(bus.retired), 32'd1);

      tag = "ld_stall3";
      run_instr(OP_LD, 0, 3, 1'b0, 1'b1);
      chk("ld_len", 32'(last_len), 32'd8);
      chk("ld_retired", 32'(bus.retired), 32'd2);

      tag = "beq_taken";
      run_instr(OP_BEQ, 0, 0, 1'b1, 1'b1);
      chk("beq1_len", 32'(last_len), 32'd3);
      tag = "beq_not_taken";
      run_instr(OP_BEQ, 0, 0, 1'b0, 1'b1);
      chk("beq0_len", 32'(last_len), 32'd3);

      tag = "run_drop";
      run_instr(OP_R, 0, 0, 1'b0, 1'b0);
      chk("run_drop_state", 32'(bus.state), 32'd0);
      idle_cycles(2);

      tag = "illegal";
      run_instr(OP_BAD, 0, 0, 1'b0, 1'b1);
      halt_hold(4);
      chk("illegal_state", 32'(bus.state), 32'd6);
      chk("illegal_flag", 32'(bus.illegal), 32'd1);
      chk("illegal_busy", 32'(bus.busy), 32'd0);
      chk("illegal_retired", 32'(bus.retired), 32'd5);

      do_reset();
      tag = "fetch_timeout";
      run_instr(OP_R, 20, 0, 1'b0, 1'b1);
      chk("fetch_to_len", 32'(last_len), 32'd15);
      halt_hold(3);
      chk("fetch_to_flag", 32'(bus.timeout), 32'd1);
      chk("fetch_to_req", 32'(bus.imem_req), 32'd0);

      do_reset();
      tag = "fetch_ready_last";
      run_instr(OP_R, 14, 0, 1'b0, 1'b1);
      chk("fetch_ready_len", 32'(last_len), 32'd18);
      chk("fetch_ready_retired", 32'(bus.retired), 32'd1);

      tag = "sd_reset";
      abort_mem = 1;
      run_instr(OP_SD, 0, 3, 1'b0, 1'b1);
      chk("sd_reset_state", 32'(bus.state), 32'd0);

      tag = "mem_timeout";
      run_instr(OP_LD, 1, 20, 1'b0, 1'b1);
      halt_hold(3);
      chk("mem_to_flag", 32'(bus.timeout), 32'd1);
      chk("mem_to_read", 32'(bus.mem_read), 32'd0);

      do_reset();
      tag = "retire_wrap";
      for (int i = 0; i < 16; i++) run_instr(OP_R, 0, 0, 1'b0, 1'b1);
      chk("wrap_retired", 32'(bus.retired), 32'd0);

      tag = "random";
      for (int n = 0; n < 150; n++) begin
         if (m_idle) idle_cycles(int'($urandom_range(0, 2)));
         run_instr(ops[$urandom_range(0, 3)], rnd_stall(), rnd_stall(),
                   1'($urandom), ($urandom_range(0, 3) != 0));
      end
      chk("random_halt", 32'(m_halt), 32'd0);

      exp_valid = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
